lm_iq_ctrl: RTL and testbench

LM_IQ_CTRL -- requirements
Module: lm_iq_ctrl

---
 rtl/lm_iq_ctrl.sv | 127 ++++++++++++
 tb/tb_lm_iq_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lm_iq_ctrl.sv
// lm_iq_ctrl -- SRAM-backed in-order queue controller.
//
// Pushes are written straight into a single-port-per-direction SRAM. Reads
// are prefetched into a 2-entry output buffer (ob) so pop_valid/pop_data come
// from registers and one push plus one pop can retire every cycle.
//
// Ports:
//   CLK, RSTN             clock, synchronous active-low reset
//   flush                 synchronous queue clear (contents discarded)
//   push_valid/ready/data write handshake
//   pop_valid/ready/data  read handshake (pop_data registered)
//   mem_cena/aa/qa        SRAM read port (cena active low, qa valid 1 cycle later)
//   mem_cenb/ab/db        SRAM write port (cenb active low)
//   count/empty/full      occupancy: count = sram + inflight + ob
module lm_iq_ctrl #(
  parameter int DW = 512,
  parameter int AW = 9
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          flush,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [DW-1:0] pop_data,
  output logic          mem_cena,
  output logic [AW-1:0] mem_aa,
  input  logic [DW-1:0] mem_qa,
  output logic          mem_cenb,
  output logic [AW-1:0] mem_ab,
  output logic [DW-1:0] mem_db,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);

  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_sram_cnt;
  logic [1:0]    r_ob_cnt;
  logic          r_inflight;
  logic [DW-1:0] r_ob0, r_ob1;   // r_ob0 is the head

  logic          w_active, w_push, w_pop, w_rd, w_sram_full;
  logic [2:0]    w_occ;
  logic [AW:0]   w_total;

  assign w_active    = RSTN && !flush;
  assign w_sram_full = (r_sram_cnt == DEPTH_C);
  assign w_push      = w_active && push_valid && !w_sram_full;
  assign w_pop       = w_active && (r_ob_cnt != 2'd0) && pop_ready;
  // Slots the ob will hold once this cycle's pop retires; a read is only
  // launched if its data is guaranteed a free slot on arrival.
  assign w_occ       = {1'b0, r_ob_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  // sram_cnt only counts words written at an earlier edge, so a word is never
  // read in the cycle it is written.
  assign w_rd        = w_active && (r_sram_cnt != '0) && (w_occ < 3'd2);

  assign push_ready = w_active && !w_sram_full;
  assign pop_valid  = RSTN && (r_ob_cnt != 2'd0);
  assign pop_data   = r_ob0;

  assign mem_cena = !w_rd;
  assign mem_aa   = r_rptr;
  assign mem_cenb = !w_push;
  assign mem_ab   = r_wptr;
  assign mem_db   = push_data;

  assign w_total = r_sram_cnt + (AW+1)'(r_inflight) + (AW+1)'(r_ob_cnt);
  assign count   = RSTN ? w_total : '0;
  assign empty   = (count == '0);
  assign full    = RSTN && w_sram_full;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_sram_cnt <= '0;
      r_ob_cnt   <= 2'd0;
      r_inflight <= 1'b0;
      r_ob0      <= '0;
      r_ob1      <= '0;
    end else if (flush) begin
      // Dropping inflight discards the read data arriving next cycle.
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_sram_cnt <= '0;
      r_ob_cnt   <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_rd)   r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_rd})
        2'b10:   r_sram_cnt <= r_sram_cnt + 1'b1;
        2'b01:   r_sram_cnt <= r_sram_cnt - 1'b1;
        default: ;
      endcase
      r_inflight <= w_rd;

      // r_inflight marks mem_qa as holding last cycle's read.
      case ({r_inflight, w_pop})
        2'b11: begin
          if (r_ob_cnt == 2'd2) begin
            r_ob0 <= r_ob1;
            r_ob1 <= mem_qa;
          end else begin
            r_ob0 <= mem_qa;
          end
        end
        2'b10: begin
          if (r_ob_cnt == 2'd0) r_ob0 <= mem_qa;
          else                  r_ob1 <= mem_qa;
          r_ob_cnt <= r_ob_cnt + 2'd1;
        end
        2'b01: begin
          r_ob0    <= r_ob1;
          r_ob_cnt <= r_ob_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lm_iq_ctrl.sv
module tb_lm_iq_ctrl;
  localparam int DW = 512;
  localparam int AW = 9;

  logic          CLK = 1'b0;
  logic          RSTN, flush, push_valid, pop_ready;
  logic          push_ready, pop_valid, mem_cena, mem_cenb, empty, full;
  logic [DW-1:0] push_data, pop_data, mem_qa, mem_db;
  logic [AW-1:0] mem_aa, mem_ab;
  logic [AW:0]   count;

  int checks = 0;
  int failures = 0;
  int seq = 0;

  always #5 CLK = ~CLK;

  lm_iq_ctrl #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RSTN(RSTN), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .mem_cena(mem_cena), .mem_aa(mem_aa), .mem_qa(mem_qa),
    .mem_cenb(mem_cenb), .mem_ab(mem_ab), .mem_db(mem_db),
    .count(count), .empty(empty), .full(full)
  );

  // SRAM: synchronous write, read data one cycle after cena.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  initial mem_qa = '0;
  always @(posedge CLK) begin
    if (!mem_cenb) sram[mem_ab] <= mem_db;
    if (!mem_cena) mem_qa <= sram[mem_aa];
  end

  task automatic chk(input bit ok, input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int v);
    logic [31:0] t;
    t = v;
    return {16{t}};
  endfunction

  // Behavioural model: the queue holds every accepted word not yet popped.
  logic [DW-1:0] q[$];
  int            mw = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge CLK) begin : mon
    logic [DW-1:0] e;
    if (!RSTN) begin
      chk({push_ready, pop_valid, mem_cena, mem_cenb, empty, full} == 6'b001110, "rst_outs",
          DW'({push_ready, pop_valid, mem_cena, mem_cenb, empty, full}), DW'(6'b001110));
      chk(count == '0, "rst_count", DW'(count), '0);
      q.delete();
      mw = 0;
      prev_stall = 0;
    end else begin
      chk(int'(count) == q.size(), "count", DW'(count), DW'(q.size()));
      chk(empty == (q.size() == 0), "empty", DW'(empty), DW'(q.size() == 0));
      chk(push_ready == (!full && !flush), "push_ready", DW'(push_ready), DW'(!full && !flush));
      if (prev_stall)
        chk(pop_valid && pop_data == prev_data, "stall_hold", pop_data, prev_data);
      if (!mem_cena && !mem_cenb)
        chk(mem_aa != mem_ab, "rw_collide", DW'(mem_aa), DW'(mem_ab));
      if (flush) begin
        chk(mem_cena && mem_cenb, "flush_mem_idle", DW'({mem_cena, mem_cenb}), DW'(2'b11));
        q.delete();
        mw = 0;
        prev_stall = 0;
      end else begin
        if (pop_valid && pop_ready) begin
          if (q.size() == 0) chk(1'b0, "pop_underflow", pop_data, '0);
          else begin
            e = q.pop_front();
            chk(pop_data == e, "pop_data", pop_data, e);
          end
        end
        if (push_valid && push_ready) begin
          chk(!mem_cenb && mem_ab == AW'(mw) && mem_db == push_data, "sram_write",
              DW'(mem_ab), DW'(mw));
          q.push_back(push_data);
          mw = (mw + 1) % (1 << AW);
        end else begin
          chk(mem_cenb, "no_write", DW'(mem_cenb), DW'(1));
        end
        prev_stall = pop_valid && !pop_ready;
        prev_data  = pop_data;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    push_valid = 1'b0;
    pop_ready  = 1'b1;
    #1;
    while (!empty && n < 2000) begin
      tick();
      #1;
      n++;
    end
    chk(empty, nm, DW'(count), '0);
  endtask

  task automatic flush_test(input bit use_rst, input string nm);
    int n;
    pop_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      push_valid = 1'b1;
      push_data  = mk(seq);
      seq++;
      tick();
    end
    push_valid = 1'b0;
    tick(); tick(); tick();
    #1;
    chk(int'(count) == 100, {nm, "_count100"}, DW'(count), DW'(100));
    pop_ready = 1'b1;      // one pop frees a slot, so a read launches now
    tick();
    pop_ready = 1'b0;
    if (use_rst) RSTN = 1'b0;
    else         flush = 1'b1;
    #1;
    if (!use_rst) chk(int'(count) == 99, {nm, "_pre"}, DW'(count), DW'(99));
    tick();
    RSTN  = 1'b1;
    flush = 1'b0;
    #1;
    chk(count == '0 && empty && !pop_valid, {nm, "_post"}, DW'({count, empty, pop_valid}), DW'(2'b10));
    pop_ready  = 1'b1;
    push_valid = 1'b1;
    push_data  = DW'(1);
    tick();
    push_valid = 1'b0;
    n = 0;
    #1;
    while (!pop_valid && n < 10) begin
      tick();
      #1;
      n++;
    end
    chk(pop_valid && pop_data == DW'(1), {nm, "_repush"}, pop_data, DW'(1));
    drain({nm, "_drain"});
  endtask

  initial begin : stim
    int acc, ign, sent, pops;
    RSTN = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0; push_data = '0;
    tick(); tick(); tick();
    RSTN = 1'b1;
    #1;
    chk(pop_data == '0 && count == '0 && !pop_valid && push_ready, "after_reset", pop_data, '0);
    tick();

    // Single word latency.
    pop_ready  = 1'b1;
    push_valid = 1'b1;
    push_data  = {64{8'hA5}};
    #1;
    chk(!mem_cenb && mem_ab == '0 && mem_db == {64{8'hA5}}, "t0_write", DW'({mem_cenb, mem_ab}), '0);
    tick();
    push_valid = 1'b0;
    #1;
    chk(!mem_cena && mem_aa == '0 && !pop_valid, "t1_read", DW'({mem_cena, mem_aa}), '0);
    tick(); #1;
    chk(!pop_valid, "t2_no_pop", DW'(pop_valid), '0);
    tick(); #1;
    chk(pop_valid && pop_data == {64{8'hA5}}, "t3_pop", pop_data, {64{8'hA5}});
    tick(); #1;
    chk(count == '0 && empty, "t4_empty", DW'(count), '0);

    // Fill: two words drain into the ob, so the SRAM fills after 514 pushes.
    pop_ready = 1'b0;
    acc = 0;
    for (int n = 0; n < 700; n++) begin
      push_valid = 1'b1;
      push_data  = mk(seq);
      #1;
      if (!push_ready) break;
      acc++;
      seq++;
      tick();
    end
    chk(acc == 514, "fill_accepted", DW'(acc), DW'(514));
    chk(int'(count) == 514 && full, "fill_count", DW'(count), DW'(514));
    ign = 0;
    for (int n = 0; n < 513; n++) begin
      push_valid = 1'b1;
      #1;
      if (push_ready) ign++;
      tick();
    end
    #1;
    chk(ign == 0 && int'(count) == 514, "fill_ignored", DW'(ign), '0);
    drain("fill_drain");

    // Wrap-around with random handshakes.
    sent = 0;
    for (int n = 0; n < 8000; n++) begin
      push_valid = (sent < 1200) && ($urandom_range(0, 3) != 0);
      push_data  = mk(seq);
      pop_ready  = ($urandom_range(0, 2) != 0);
      #1;
      if (push_valid && push_ready) begin
        sent++;
        seq++;
      end
      if (sent == 1200 && empty) break;
      tick();
    end
    chk(sent == 1200 && empty, "wrap_done", DW'(sent), DW'(1200));

    // Throughput.
    pops = 0;
    pop_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      push_valid = 1'b1;
      push_data  = mk(seq);
      #1;
      if (push_ready) seq++;
      if (i >= 10 && pop_valid) pops++;
      tick();
    end
    chk(pops == 90, "throughput", DW'(pops), DW'(90));
    drain("thru_drain");

    // Backpressure: pop_ready toggles every cycle.
    for (int i = 0; i < 60; i++) begin
      push_valid = (i < 30);
      push_data  = mk(seq);
      pop_ready  = i[0];
      #1;
      if (push_valid && push_ready) seq++;
      tick();
    end
    push_valid = 1'b0;
    for (int n = 0; n < 400 && !empty; n++) begin
      pop_ready = ~pop_ready;
      tick();
      #1;
    end
    chk(empty, "bp_drain", DW'(count), '0);

    flush_test(1'b0, "flush");
    flush_test(1'b1, "reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
